// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle for seven_seg_scanner: BCD/dp capture inputs and the
// multiplexed segment/anode outputs.
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output digits_in, dp_in, load,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  digits_in, dp_in, load,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with frame-aligned capture.
// Optional leading-zero suppression is compiled in with LEADING_ZERO_BLANK_EN.
//
//   state    | meaning
//   ST_BLANK | slot start, all anodes off for BLANK_CYCLES (anti-ghosting)
//   ST_SHOW  | anode of digit idx on, segments from the active word
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    seven_seg_scanner_if.slave bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DW-1:0]         active;
    logic [DW-1:0]         pending;
    logic [NUM_DIGITS-1:0] active_dp;
    logic [NUM_DIGITS-1:0] pending_dp;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  pending_valid;

    logic                  cnt_last;
    logic                  idx_last;
    logic                  boundary;
    logic [CW-1:0]         cnt_nxt;
    logic [IW-1:0]         idx_nxt;
    logic [DW-1:0]         active_nxt;
    logic [NUM_DIGITS-1:0] active_dp_nxt;
    logic [NUM_DIGITS-1:0] blank_nxt;
    int                    show_sel;
    logic [3:0]            show_bcd;
    logic [6:0]            show_seg;
    logic                  show_dp;

    function automatic logic [6:0] seg_lut(input logic [3:0] v);
        case (v)
            4'd0:    seg_lut = 7'h40;
            4'd1:    seg_lut = 7'h79;
            4'd2:    seg_lut = 7'h24;
            4'd3:    seg_lut = 7'h30;
            4'd4:    seg_lut = 7'h19;
            4'd5:    seg_lut = 7'h12;
            4'd6:    seg_lut = 7'h02;
            4'd7:    seg_lut = 7'h78;
            4'd8:    seg_lut = 7'h00;
            4'd9:    seg_lut = 7'h10;
            default: seg_lut = 7'h7F;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Blank zeros from the top digit down; digit 0 and any digit with a lit dp end the run.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DW-1:0] bcd,
                                                      input logic [NUM_DIGITS-1:0] dpv);
        logic sup;
        lz_mask = '0;
        sup     = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (sup && bcd[4*i +: 4] == 4'd0 && !dpv[i]) lz_mask[i] = 1'b1;
            else                                       sup        = 1'b0;
        end
    endfunction
`endif

    always_comb begin
        cnt_last = (cnt == CW'(REFRESH_DIV - 1));
        idx_last = (idx == IW'(NUM_DIGITS - 1));
        boundary = cnt_last && idx_last;
        cnt_nxt  = cnt_last ? '0 : cnt + CW'(1);
        idx_nxt  = idx;
        if (cnt_last) idx_nxt = idx_last ? '0 : idx + IW'(1);

        active_nxt    = active;
        active_dp_nxt = active_dp;
        if (boundary) begin
            if (bus.load) begin
                active_nxt    = bus.digits_in;
                active_dp_nxt = bus.dp_in;
            end else if (pending_valid) begin
                active_nxt    = pending;
                active_dp_nxt = pending_dp;
            end
        end

`ifdef LEADING_ZERO_BLANK_EN
        blank_nxt = boundary ? lz_mask(active_nxt, active_dp_nxt) : blank_mask;
`else
        blank_nxt = '0;
`endif

        show_sel = int'(idx_nxt);
        show_bcd = active_nxt[4*show_sel +: 4];
        show_seg = blank_nxt[show_sel] ? 7'h7F : seg_lut(show_bcd);
        show_dp  = ~active_dp_nxt[show_sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_BLANK;
            cnt            <= '0;
            idx            <= '0;
            active         <= '1;
            active_dp      <= '0;
            pending        <= '1;
            pending_dp     <= '0;
            pending_valid  <= 1'b0;
            blank_mask     <= '0;
            bus.an         <= '1;
            bus.seg        <= 7'h7F;
            bus.dp         <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            cnt            <= cnt_nxt;
            idx            <= idx_nxt;
            active         <= active_nxt;
            active_dp      <= active_dp_nxt;
            blank_mask     <= blank_nxt;
            bus.frame_done <= boundary;

            if (bus.load && !boundary) begin
                pending       <= bus.digits_in;
                pending_dp    <= bus.dp_in;
                pending_valid <= 1'b1;
            end else if (boundary) begin
                pending_valid <= 1'b0;
            end

            // Outputs follow the next counter value so they switch on the same edge as the FSM.
            if (cnt_nxt == CW'(BLANK_CYCLES)) begin
                state   <= ST_SHOW;
                bus.an  <= ~(NUM_DIGITS'(1) << idx_nxt);
                bus.seg <= show_seg;
                bus.dp  <= show_dp;
            end else if (cnt_last) begin
                state   <= ST_BLANK;
                bus.an  <= '1;
                bus.seg <= 7'h7F;
                bus.dp  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (4 digits, 8-cycle slots, 2 blank cycles).
module tb_seven_seg_scanner;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scanner_if #(.NUM_DIGITS(ND)) ssif ();

    seven_seg_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ssif)
    );

    typedef struct {
        int         fr;
        int         dig;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input int f, input logic [15:0] bcd, input logic [3:0] dpv);
        logic [3:0] blank;
        logic [3:0] nib;
        exp_t       e;
        blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            bit sup;
            sup = 1'b1;
            for (int i = 3; i >= 1; i--) begin
                if (sup && bcd[4*i +: 4] == 4'd0 && !dpv[i]) blank[i] = 1'b1;
                else                                       sup      = 1'b0;
            end
        end
`endif
        for (int d = 0; d < ND; d++) begin
            nib   = bcd[4*d +: 4];
            e.fr  = f;
            e.dig = d;
            e.an  = ~(4'b0001 << d);
            e.seg = blank[d] ? 7'h7F : seg_tbl[nib];
            e.dp  = ~dpv[d];
            sb.push_back(e);
        end
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] d);
        ssif.digits_in = v;
        ssif.dp_in     = d;
        ssif.load      = 1'b1;
        @(negedge clk);
        ssif.load      = 1'b0;
    endtask

    task automatic wait_fd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (ssif.frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("fd_wait", 32'(seen), 32'd1);
    endtask

    // Output monitor: frame/slot tracking, timing checks and scoreboard pops
    int cyc        = 0;
    int last_fd    = -1;
    int fr         = 0;
    int slot       = 0;
    int blank_run  = 0;
    int onehot_bad = 0;
    bit prev_all   = 1'b1;
    bit fd_prev    = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            fr        = 0;
            slot      = 0;
            blank_run = 0;
            prev_all  = 1'b1;
            fd_prev   = 1'b0;
            last_fd   = -1;
        end else begin
            if (fd_prev) chk("fd_width", 32'(ssif.frame_done), 32'd0);
            if (ssif.frame_done) begin
                if (last_fd >= 0) chk("fd_period", cyc - last_fd, ND * RD);
                last_fd = cyc;
                fr++;
                slot = 0;
            end
            fd_prev = ssif.frame_done;
            if ($countones(~ssif.an) > 1) onehot_bad++;
            if (!(&ssif.an) && prev_all) begin
                if (fr >= 1) chk("blank_len", blank_run, BC);
                while (sb.size() > 0 && (sb[0].fr < fr || (sb[0].fr == fr && sb[0].dig < slot))) begin
                    chk("sb_skipped", sb[0].fr * 16 + sb[0].dig, fr * 16 + slot);
                    void'(sb.pop_front());
                end
                if (sb.size() > 0 && sb[0].fr == fr && sb[0].dig == slot) begin
                    chk("an",  32'(ssif.an),  32'(sb[0].an));
                    chk("seg", 32'(ssif.seg), 32'(sb[0].seg));
                    chk("dp",  32'(ssif.dp),  32'(sb[0].dp));
                    void'(sb.pop_front());
                end
                slot++;
            end
            if (&ssif.an) blank_run++;
            else          blank_run = 0;
            prev_all = &ssif.an;
        end
    end

    initial begin
        int  n;
        bit  lit;
        ssif.digits_in = '0;
        ssif.dp_in     = '0;
        ssif.load      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an",  32'(ssif.an),         32'hF);
        chk("rst_seg", 32'(ssif.seg),        32'h7F);
        chk("rst_dp",  32'(ssif.dp),         32'd1);
        chk("rst_fd",  32'(ssif.frame_done), 32'd0);
        push_frame(0, 16'hFFFF, 4'b0000);
        #1 rst_n = 1'b1;

        // basic load, then two loads inside one frame (last wins, next frame only)
        repeat (4) @(negedge clk);
        push_frame(1, 16'h1234, 4'b0000);
        push_frame(2, 16'h1234, 4'b0000);
        load_val(16'h1234, 4'b0000);
        wait_fd();
        wait_fd();
        repeat (5) @(negedge clk);
        load_val(16'h5678, 4'b0000);
        repeat (3) @(negedge clk);
        push_frame(3, 16'h9999, 4'b0001);
        load_val(16'h9999, 4'b0001);
        wait_fd();

        // load on the boundary cycle goes straight to active
        repeat (31) @(negedge clk);
        push_frame(4, 16'h0042, 4'b0000);
        ssif.digits_in = 16'h0042;
        ssif.dp_in     = 4'b0000;
        ssif.load      = 1'b1;
        @(negedge clk);
        ssif.load      = 1'b0;
        chk("bnd_align", 32'(ssif.frame_done), 32'd1);

        // zeros with and without a decimal point
        repeat (5) @(negedge clk);
        push_frame(5, 16'h0000, 4'b0100);
        load_val(16'h0000, 4'b0100);
        wait_fd();
        repeat (3) @(negedge clk);
        push_frame(6, 16'h0000, 4'b0000);
        load_val(16'h0000, 4'b0000);
        wait_fd();

        // reset in the middle of digit 2's SHOW phase
        repeat (20) @(negedge clk);
        chk("pre_rst_an", 32'(ssif.an), 32'b1011);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_an",  32'(ssif.an),         32'hF);
        chk("mid_rst_seg", 32'(ssif.seg),        32'h7F);
        chk("mid_rst_dp",  32'(ssif.dp),         32'd1);
        chk("mid_rst_fd",  32'(ssif.frame_done), 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        push_frame(0, 16'hFFFF, 4'b0000);
        push_frame(1, 16'hFFFF, 4'b0000);
        #1 rst_n = 1'b1;
        n   = 0;
        lit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (!(&ssif.an)) begin
                lit = 1'b1;
                break;
            end
        end
        chk("first_lit_seen", 32'(lit), 32'd1);
        chk("first_lit_cyc",  n,         BC);
        wait_fd();
        wait_fd();
        repeat (3) @(negedge clk);

        chk("onehot", onehot_bad, 0);
        chk("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
